// File: rtl/data_memory_mmio_if.sv
// Data-memory bus between the single-cycle core (master) and the data-side responder (slave).
// The core drives the address, store data, store strobe and access size; the responder returns load data and status.
interface data_memory_mmio_if #(
    parameter int N_Bits = 32
);
    logic              MemWrite;
    logic [1:0]        MemSize;
    logic [N_Bits-1:0] A;
    logic [N_Bits-1:0] WD;
    logic [N_Bits-1:0] RD;
    logic [N_Bits-1:0] Port_Out;
    logic              Misaligned;

    modport master (
        output MemWrite, MemSize, A, WD,
        input  RD, Port_Out, Misaligned
    );

    modport slave (
        input  MemWrite, MemSize, A, WD,
        output RD, Port_Out, Misaligned
    );
endinterface

// File: rtl/data_memory_mmio.sv
// Data-side responder: word-organised RAM with byte/half/word lanes, plus an MMIO window
// holding an output port register and a free-running cycle counter.
module data_memory_mmio #(
    parameter int          N_Bits      = 32,
    parameter int          Depth_Words = 1024,
    parameter logic [31:0] MMIO_Base   = 32'hFFFF_FFF0
) (
    input logic               clk,
    input logic               rst,
    data_memory_mmio_if.slave bus
);
    localparam int IDX_W = $clog2(Depth_Words);

    logic [N_Bits-1:0] mem [Depth_Words];
    logic [N_Bits-1:0] port_out_q;
    logic [N_Bits-1:0] counter_q;
    logic              misaligned_q;

    logic              is_mmio;
    logic [1:0]        mmio_off;
    logic [IDX_W-1:0]  idx;
    logic              aligned;
    logic              store_ok;
    logic [3:0]        be;
    logic [N_Bits-1:0] wdata;
    logic [N_Bits-1:0] word_sel;
    logic [N_Bits-1:0] rd_c;

    always_comb begin
        is_mmio  = (bus.A[N_Bits-1:4] == MMIO_Base[N_Bits-1:4]);
        mmio_off = bus.A[3:2];
        idx      = bus.A[IDX_W+1:2];

        case (bus.MemSize)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~bus.A[0];
            default: aligned = (bus.A[1:0] == 2'b00);
        endcase

        // Store data is replicated across lanes so each lane picks its byte by position.
        case (bus.MemSize)
            2'b00: begin
                be    = 4'b0001 << bus.A[1:0];
                wdata = {4{bus.WD[7:0]}};
            end
            2'b01: begin
                be    = bus.A[1] ? 4'b1100 : 4'b0011;
                wdata = {2{bus.WD[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = bus.WD;
            end
        endcase

        store_ok = bus.MemWrite & aligned & ~rst;
    end

    always_comb begin
        word_sel = '0;
        if (is_mmio) begin
            case (mmio_off)
                2'd0:    word_sel = port_out_q;
                2'd1:    word_sel = counter_q;
                default: word_sel = '0;
            endcase
        end else begin
            word_sel = mem[idx];
        end

        rd_c = '0;
        if (aligned) begin
            case (bus.MemSize)
                2'b00:   rd_c = {{(N_Bits-8){1'b0}}, word_sel[8*bus.A[1:0] +: 8]};
                2'b01:   rd_c = {{(N_Bits-16){1'b0}}, word_sel[16*bus.A[1] +: 16]};
                default: rd_c = word_sel;
            endcase
        end
    end

    // RAM has no reset; rst still blocks a store in the same cycle.
    always_ff @(posedge clk) begin
        if (store_ok && !is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            port_out_q <= '0;
        end else if (store_ok && is_mmio && mmio_off == 2'd0) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) port_out_q[8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Only a full word store reloads the counter; narrower stores leave it counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter_q <= '0;
        end else if (store_ok && is_mmio && mmio_off == 2'd1 && bus.MemSize[1]) begin
            counter_q <= bus.WD;
        end else begin
            counter_q <= counter_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misaligned_q <= 1'b0;
        end else if (!aligned) begin
            misaligned_q <= 1'b1;
        end
    end

    assign bus.RD         = rd_c;
    assign bus.Port_Out   = port_out_q;
    assign bus.Misaligned = misaligned_q;
endmodule
